// File: rtl/dram_host_ctrl.sv
// Host-side command sequencer for the Dram model: one request at a time, issues the
// device strobe, times the write-data slot from shadow WL and captures read/MRR data.
module dram_host_ctrl #(
  parameter int unsigned RL_RST   = 8,
  parameter int unsigned WL_RST   = 8,
  parameter int unsigned TO_SLACK = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic       R,
  output logic       W,
  output logic       MRW,
  output logic       MRR,
  output logic [7:0] ADDR,
  output logic [7:0] DQ_IN,
  output logic       DRIV_VALID,
  input  logic [7:0] DQ_OUT,
  input  logic       DQ_OE
);

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_MRW = 2'b10,
    OP_MRR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WR_WAIT,
    RD_WAIT,
    MRR_CAP,
    RESP
  } state_e;

  localparam logic [9:0] SLACK10 = 10'(TO_SLACK);

  state_e     state_q, state_d;
  op_e        op_q;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] rl_q, wl_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;
  logic [9:0] cnt_q;
  logic [9:0] rd_limit;
  logic       wr_slot;

  // Timeout bound kept in 10 bits so rl=255 does not wrap.
  assign rd_limit = {2'b00, rl_q} + 10'd2 + SLACK10;
  assign wr_slot  = (cnt_q == {2'b00, wl_q});

  assign ADDR     = addr_q;
  assign DQ_IN    = wdata_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_ERR  = rsp_err_q;

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    R          = 1'b0;
    W          = 1'b0;
    MRW        = 1'b0;
    MRR        = 1'b0;
    DRIV_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = ~RST;
        if (REQ_VALID) state_d = ISSUE;
      end
      ISSUE: begin
        R   = (op_q == OP_RD);
        W   = (op_q == OP_WR);
        MRW = (op_q == OP_MRW);
        MRR = (op_q == OP_MRR);
        case (op_q)
          OP_RD:   state_d = RD_WAIT;
          OP_WR:   state_d = WR_WAIT;
          OP_MRR:  state_d = MRR_CAP;
          default: state_d = RESP;
        endcase
      end
      WR_WAIT: begin
        DRIV_VALID = wr_slot;
        if (wr_slot) state_d = RESP;
      end
      RD_WAIT: begin
        if (DQ_OE || (cnt_q == rd_limit)) state_d = RESP;
      end
      MRR_CAP: state_d = RESP;
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the async reset abandons any transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rl_q       <= 8'(RL_RST);
      wl_q       <= 8'(WL_RST);
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            op_q    <= op_e'(REQ_OP);
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          if (op_q == OP_MRW) begin
            if (addr_q == 8'd0)      rl_q <= wdata_q;
            else if (addr_q == 8'd1) wl_q <= wdata_q;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        WR_WAIT: begin
          cnt_q <= cnt_q + 10'd1;
          if (wr_slot) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q + 10'd1;
          // A data strobe arriving on the last allowed cycle still wins over the timeout.
          if (DQ_OE) begin
            rsp_data_q <= DQ_OUT;
            rsp_err_q  <= 1'b0;
          end else if (cnt_q == rd_limit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        MRR_CAP: begin
          rsp_data_q <= DQ_OUT;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
